cmd_issue_sequencer: RTL and testbench

Sits between the timing controller and the DRAM PHY command/address pins. It takes each scheduled command and its burst index, gathers the selected burst's address fields, and serialises the command as a 3-phase frame on an 8-bit CA bus. For read and write commands it also times the data window and tells the burst buffers when to drive or capture data.

---
 rtl/cmd_issue_sequencer_pkg.sv | 40 ++++
 rtl/cmd_issue_sequencer_data_window_tracker.sv | 138 +++++++++++++
 rtl/cmd_issue_sequencer.sv | 148 ++++++++++++++
 tb/tb_cmd_issue_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_issue_sequencer_pkg.sv
// Shared command types and CA-bus encoding used by the command issue path.
package types_def;

    typedef enum logic [2:0] {
        CMD_NONE        = 3'd0,
        CMD_ACTIVATE    = 3'd1,
        CMD_READ        = 3'd2,
        CMD_WRITE       = 3'd3,
        CMD_PRECHARGE   = 3'd4,
        CMD_REFRESH_ALL = 3'd5
    } command_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_P0,
        ST_P1,
        ST_P2
    } frame_state_t;

    localparam logic [3:0] OP_IDLE        = 4'd0;
    localparam logic [3:0] OP_ACTIVATE    = 4'd1;
    localparam logic [3:0] OP_READ        = 4'd2;
    localparam logic [3:0] OP_WRITE       = 4'd3;
    localparam logic [3:0] OP_PRECHARGE   = 4'd4;
    localparam logic [3:0] OP_REFRESH_ALL = 4'd5;

    localparam int CMD_PHASES = 3;

    function automatic logic [3:0] cmd_opcode(input command_t c);
        case (c)
            CMD_ACTIVATE:    return OP_ACTIVATE;
            CMD_READ:        return OP_READ;
            CMD_WRITE:       return OP_WRITE;
            CMD_PRECHARGE:   return OP_PRECHARGE;
            CMD_REFRESH_ALL: return OP_REFRESH_ALL;
            default:         return OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_issue_sequencer_data_window_tracker.sv
// Tracks pending read/write data windows and drives the beat strobes of the one
// currently owning the data path; late overlapping windows are dropped.
module data_window_tracker
    import types_def::*;
#(
    parameter int WIN_DEPTH  = 2,
    parameter int RD_TO_DATA = 6,
    parameter int WR_TO_DATA = 5,
    parameter int BURST_TIME = 8,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             load_dir,
    input  logic [IDX_W-1:0] load_idx,
    output logic             full_o,
    output logic             overlap_o,
    output logic             data_en_o,
    output logic             data_dir_o,
    output logic [IDX_W-1:0] data_index_o,
    output logic             data_first_o,
    output logic             data_last_o
);

    localparam int MAX_DLY = (RD_TO_DATA > WR_TO_DATA) ? RD_TO_DATA : WR_TO_DATA;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);
    localparam int BEAT_W  = (BURST_TIME > 1) ? $clog2(BURST_TIME) : 1;
    localparam int SEL_W   = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_TIME - 1);

    typedef struct packed {
        logic             valid;
        logic             active;
        logic             dir;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } win_t;

    win_t              win_q [WIN_DEPTH];
    logic [BEAT_W-1:0] beat_q;

    logic                 act_any, start_any, start_go, engine_done, load_ok;
    logic [SEL_W-1:0]     act_sel, start_sel, load_sel;
    logic [WIN_DEPTH-1:0] starting, free_mask;

    function automatic int unsigned win_delay(input logic dir);
        return dir ? RD_TO_DATA : WR_TO_DATA;
    endfunction

    // Among windows reaching zero together, the longer delay was loaded earlier.
    always_comb begin
        act_any   = 1'b0;
        act_sel   = '0;
        start_any = 1'b0;
        start_sel = '0;
        starting  = '0;
        for (int i = 0; i < WIN_DEPTH; i++) begin
            if (win_q[i].valid && win_q[i].active) begin
                act_any = 1'b1;
                act_sel = SEL_W'(i);
            end
            if (win_q[i].valid && !win_q[i].active && win_q[i].cnt == '0) begin
                starting[i] = 1'b1;
                if (!start_any || win_delay(win_q[i].dir) > win_delay(win_q[start_sel].dir)) begin
                    start_any = 1'b1;
                    start_sel = SEL_W'(i);
                end
            end
        end

        engine_done = act_any && (beat_q == LAST_BEAT);
        start_go    = start_any && (!act_any || engine_done);

        free_mask = '0;
        overlap_o = 1'b0;
        for (int i = 0; i < WIN_DEPTH; i++) begin
            if (engine_done && act_sel == SEL_W'(i)) begin
                free_mask[i] = 1'b1;
            end
            if (starting[i] && !(start_go && start_sel == SEL_W'(i))) begin
                free_mask[i] = 1'b1;
                overlap_o    = 1'b1;
            end
        end

        // An entry being freed this cycle may be reused by a same-cycle load.
        load_ok  = 1'b0;
        load_sel = '0;
        for (int i = 0; i < WIN_DEPTH; i++) begin
            if (!load_ok && (!win_q[i].valid || free_mask[i])) begin
                load_ok  = 1'b1;
                load_sel = SEL_W'(i);
            end
        end
        full_o = load && !load_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every entry updates from the same pre-edge view.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                win_q[i] <= '0;
            end
            beat_q <= '0;
        end else begin
            for (int i = 0; i < WIN_DEPTH; i++) begin
                if (free_mask[i]) begin
                    win_q[i].valid  <= 1'b0;
                    win_q[i].active <= 1'b0;
                end else if (start_go && start_sel == SEL_W'(i)) begin
                    win_q[i].active <= 1'b1;
                end else if (win_q[i].valid && !win_q[i].active) begin
                    win_q[i].cnt <= win_q[i].cnt - 1'b1;
                end
                if (load && load_ok && load_sel == SEL_W'(i)) begin
                    win_q[i] <= '{valid:  1'b1,
                                  active: 1'b0,
                                  dir:    load_dir,
                                  idx:    load_idx,
                                  cnt:    CNT_W'(load_dir ? RD_TO_DATA : WR_TO_DATA)};
                end
            end
            if (start_go) begin
                beat_q <= '0;
            end else if (act_any) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign data_en_o    = act_any;
    assign data_dir_o   = act_any ? win_q[act_sel].dir : 1'b0;
    assign data_index_o = act_any ? win_q[act_sel].idx : '0;
    assign data_first_o = act_any && (beat_q == '0);
    assign data_last_o  = engine_done;

endmodule

// File: rtl/cmd_issue_sequencer.sv
// Serialises scheduled DRAM commands into 3-phase CA frames and hands read/write
// data windows to the window tracker; error flags are sticky until reset.
module cmd_issue_sequencer
    import types_def::*;
#(
    parameter int NO_OF_BURSTS = 4,
    parameter int RD_TO_DATA   = 6,
    parameter int WR_TO_DATA   = 5,
    parameter int BURST_TIME   = 8,
    parameter int WIN_DEPTH    = 2,
    localparam int IDX_W       = (NO_OF_BURSTS > 1) ? $clog2(NO_OF_BURSTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  command_t                      cmd_i,
    input  logic [IDX_W-1:0]              cmd_index_i,
    input  logic [NO_OF_BURSTS-1:0][1:0]  in_burst_address_bank,
    input  logic [NO_OF_BURSTS-1:0][1:0]  in_burst_address_bg,
    input  logic [NO_OF_BURSTS-1:0][15:0] in_burst_address_row,
    input  logic [NO_OF_BURSTS-1:0][9:0]  in_burst_address_col,
    output logic [7:0]                    ca_o,
    output logic                          cs_n_o,
    output logic                          cmd_busy_o,
    output logic                          data_en_o,
    output logic                          data_dir_o,
    output logic [IDX_W-1:0]              data_index_o,
    output logic                          data_first_o,
    output logic                          data_last_o,
    output logic [2:0]                    err_o
);

    frame_state_t state_q, state_d;
    logic [3:0]   op_q;
    logic [1:0]   bg_q, bank_q;
    logic [15:0]  addr_q, addr_d;
    logic [IDX_W-1:0] idx_q;
    logic [2:0]   err_q;

    logic cmd_valid, accept, win_load, win_full, win_overlap;

    assign cmd_valid = (cmd_i != CMD_NONE);

    always_comb begin
        addr_d = '0;
        case (cmd_i)
            CMD_ACTIVATE:        addr_d = in_burst_address_row[cmd_index_i];
            CMD_READ, CMD_WRITE: addr_d = {6'b0, in_burst_address_col[cmd_index_i]};
            default:             addr_d = '0;
        endcase
    end

    // NOTE: every output and next-state term gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        ca_o       = '0;
        cs_n_o     = 1'b1;
        cmd_busy_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_P0;
                    accept  = 1'b1;
                end
            end
            ST_P0: begin
                ca_o       = {op_q, bg_q, bank_q};
                cs_n_o     = 1'b0;
                cmd_busy_o = 1'b1;
                state_d    = ST_P1;
            end
            ST_P1: begin
                ca_o       = addr_q[15:8];
                cs_n_o     = 1'b0;
                cmd_busy_o = 1'b1;
                state_d    = ST_P2;
            end
            ST_P2: begin
                ca_o   = addr_q[7:0];
                cs_n_o = 1'b0;
                if (cmd_valid) begin
                    state_d = ST_P0;
                    accept  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_IDLE;
            bg_q    <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_opcode(cmd_i);
                bg_q   <= in_burst_address_bg[cmd_index_i];
                bank_q <= in_burst_address_bank[cmd_index_i];
                addr_q <= addr_d;
                idx_q  <= cmd_index_i;
            end
            if (cmd_valid && (state_q == ST_P0 || state_q == ST_P1)) begin
                err_q[0] <= 1'b1;
            end
            if (win_full) begin
                err_q[1] <= 1'b1;
            end
            if (win_overlap) begin
                err_q[2] <= 1'b1;
            end
        end
    end

    // The window entry lands on the same edge that moves the frame into P2.
    assign win_load = (state_q == ST_P1) && (op_q == OP_READ || op_q == OP_WRITE);

    data_window_tracker #(
        .WIN_DEPTH  (WIN_DEPTH),
        .RD_TO_DATA (RD_TO_DATA),
        .WR_TO_DATA (WR_TO_DATA),
        .BURST_TIME (BURST_TIME),
        .IDX_W      (IDX_W)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .load         (win_load),
        .load_dir     (op_q == OP_READ),
        .load_idx     (idx_q),
        .full_o       (win_full),
        .overlap_o    (win_overlap),
        .data_en_o    (data_en_o),
        .data_dir_o   (data_dir_o),
        .data_index_o (data_index_o),
        .data_first_o (data_first_o),
        .data_last_o  (data_last_o)
    );

    assign err_o = err_q;

endmodule

// File: tb/tb_cmd_issue_sequencer.sv
// Directed scenarios for the CA frame sequencer and its data window tracking.
module tb_cmd_issue_sequencer;
    import types_def::*;

    logic             clk = 1'b0;
    logic             rst;
    command_t         cmd_i;
    logic [1:0]       cmd_index_i;
    logic [3:0][1:0]  bank, bg;
    logic [3:0][15:0] row;
    logic [3:0][9:0]  col;
    logic [7:0]       ca_o;
    logic             cs_n_o, cmd_busy_o, data_en_o, data_dir_o, data_first_o, data_last_o;
    logic [1:0]       data_index_o;
    logic [2:0]       err_o;

    int checks   = 0;
    int failures = 0;

    cmd_issue_sequencer dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_i                 (cmd_i),
        .cmd_index_i           (cmd_index_i),
        .in_burst_address_bank (bank),
        .in_burst_address_bg   (bg),
        .in_burst_address_row  (row),
        .in_burst_address_col  (col),
        .ca_o                  (ca_o),
        .cs_n_o                (cs_n_o),
        .cmd_busy_o            (cmd_busy_o),
        .data_en_o             (data_en_o),
        .data_dir_o            (data_dir_o),
        .data_index_o          (data_index_o),
        .data_first_o          (data_first_o),
        .data_last_o           (data_last_o),
        .err_o                 (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        cmd_i = CMD_NONE;
        step();
        rst = 1'b0;
    endtask

    // Drives a command and walks to its P2 cycle (t = 0).
    task automatic frame_to_p2(input command_t c, input logic [1:0] s);
        cmd_i       = c;
        cmd_index_i = s;
        step();
        cmd_i = CMD_NONE;
        step();
        step();
    endtask

    task automatic test_reset();
        logic [18:0] got, exp;
        rst   = 1'b1;
        cmd_i = CMD_NONE;
        step();
        step();
        got = {ca_o, cs_n_o, cmd_busy_o, data_en_o, data_dir_o, data_index_o,
               data_first_o, data_last_o, err_o};
        exp = {8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b000};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_activate();
        logic [9:0] got;
        logic [9:0] exp [4];
        int en_seen;
        exp[0] = {8'h17, 1'b0, 1'b1};
        exp[1] = {8'hA5, 1'b0, 1'b1};
        exp[2] = {8'hC3, 1'b0, 1'b0};
        exp[3] = {8'h00, 1'b1, 1'b0};
        do_reset();
        cmd_i       = CMD_ACTIVATE;
        cmd_index_i = 2'd2;
        for (int p = 0; p < 4; p++) begin
            step();
            cmd_i = CMD_NONE;
            got = {ca_o, cs_n_o, cmd_busy_o};
            checks++;
            if (got !== exp[p]) begin
                failures++;
                $display("FAIL act_phase%0d {ca,cs_n,busy} got=%h exp=%h", p, got, exp[p]);
            end
        end
        en_seen = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (data_en_o !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0 || err_o !== 3'b000) begin
            failures++;
            $display("FAIL act_no_data en_cycles=%0d err=%b exp 0/000", en_seen, err_o);
        end
    endtask

    task automatic test_read();
        logic [5:0] got, exp;
        logic [7:0] ca_exp [3];
        ca_exp[0] = 8'h29;
        ca_exp[1] = 8'h01;
        ca_exp[2] = 8'h55;
        do_reset();
        cmd_i       = CMD_READ;
        cmd_index_i = 2'd1;
        for (int p = 0; p < 3; p++) begin
            step();
            cmd_i = CMD_NONE;
            checks++;
            if (ca_o !== ca_exp[p] || cs_n_o !== 1'b0) begin
                failures++;
                $display("FAIL read_phase%0d ca=%h cs_n=%b exp ca=%h cs_n=0", p, ca_o, cs_n_o, ca_exp[p]);
            end
        end
        for (int t = 1; t <= 18; t++) begin
            step();
            exp = {(t >= 7 && t <= 14), (t == 7), (t == 14), (t >= 7 && t <= 14), 1'b0,
                   (t >= 7 && t <= 14)};
            got = {data_en_o, data_first_o, data_last_o, data_dir_o, data_index_o};
            checks++;
            if (got !== exp || cs_n_o !== 1'b1) begin
                failures++;
                $display("FAIL read_window t=%0d {en,first,last,dir,idx}=%b exp=%b cs_n=%b", t, got, exp, cs_n_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got, exp;
        logic       en;
        do_reset();
        frame_to_p2(CMD_WRITE, 2'd0);
        cmd_i       = CMD_READ;
        cmd_index_i = 2'd1;
        for (int t = 1; t <= 20; t++) begin
            step();
            cmd_i = CMD_NONE;
            en  = (t >= 6 && t <= 13);
            exp = {en, (t == 6), (t == 13), 1'b0, 2'b00, (t >= 10) ? 3'b100 : 3'b000};
            got = {data_en_o, data_first_o, data_last_o, data_dir_o, data_index_o, err_o};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL wr_rd_overlap t=%0d {en,first,last,dir,idx,err}=%b exp=%b", t, got, exp);
            end
        end
    endtask

    task automatic test_spaced_reads();
        logic [8:0] got, exp;
        int base;
        do_reset();
        frame_to_p2(CMD_READ, 2'd0);
        for (int t = 1; t <= 42; t++) begin
            step();
            exp = '0;
            for (int k = 0; k < 3; k++) begin
                base = 12 * k;
                if (t >= base + 7 && t <= base + 14) begin
                    exp = {1'b1, (t == base + 7), (t == base + 14), 1'b1, 2'(k), 3'b000};
                end
            end
            got = {data_en_o, data_first_o, data_last_o, data_dir_o, data_index_o, err_o};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL spaced_reads t=%0d {en,first,last,dir,idx,err}=%b exp=%b", t, got, exp);
            end
            cmd_i       = (t == 9 || t == 21) ? CMD_READ : CMD_NONE;
            cmd_index_i = (t == 9) ? 2'd1 : 2'd2;
        end
        cmd_i = CMD_NONE;
    endtask

    task automatic test_window_full();
        logic [8:0] got, exp;
        logic       en;
        logic [8:0] ca_exp [3];
        ca_exp[0] = {8'h27, 1'b0};
        ca_exp[1] = {8'h02, 1'b0};
        ca_exp[2] = {8'hAB, 1'b0};
        do_reset();
        frame_to_p2(CMD_READ, 2'd0);
        cmd_i       = CMD_READ;
        cmd_index_i = 2'd1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t >= 4 && t <= 6) begin
                checks++;
                if ({ca_o, cs_n_o} !== ca_exp[t-4]) begin
                    failures++;
                    $display("FAIL full_third_frame t=%0d {ca,cs_n}=%h exp=%h", t, {ca_o, cs_n_o}, ca_exp[t-4]);
                end
            end
            en  = (t >= 7 && t <= 14);
            exp = {en, (t == 7), (t == 14), en, 2'b00,
                   (t >= 10) ? 3'b110 : (t >= 6) ? 3'b010 : 3'b000};
            got = {data_en_o, data_first_o, data_last_o, data_dir_o, data_index_o, err_o};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL window_full t=%0d {en,first,last,dir,idx,err}=%b exp=%b", t, got, exp);
            end
            cmd_i       = (t == 3) ? CMD_READ : CMD_NONE;
            cmd_index_i = 2'd2;
        end
        cmd_i = CMD_NONE;
    endtask

    task automatic test_cmd_while_busy();
        logic [11:0] got;
        logic [11:0] exp [4];
        exp[0] = {8'h50, 1'b0, 3'b000};
        exp[1] = {8'h00, 1'b0, 3'b000};
        exp[2] = {8'h00, 1'b0, 3'b001};
        exp[3] = {8'h00, 1'b1, 3'b001};
        do_reset();
        cmd_i       = CMD_REFRESH_ALL;
        cmd_index_i = 2'd3;
        for (int p = 0; p < 4; p++) begin
            step();
            cmd_i       = (p == 1) ? CMD_PRECHARGE : CMD_NONE;
            cmd_index_i = (p == 1) ? 2'd2 : 2'd3;
            got = {ca_o, cs_n_o, err_o};
            checks++;
            if (got !== exp[p]) begin
                failures++;
                $display("FAIL busy_cmd_phase%0d {ca,cs_n,err}=%h exp=%h", p, got, exp[p]);
            end
        end
        step();
        checks++;
        if (cs_n_o !== 1'b1 || err_o !== 3'b001) begin
            failures++;
            $display("FAIL busy_cmd_ignored cs_n=%b err=%b exp 1/001", cs_n_o, err_o);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        do_reset();
        frame_to_p2(CMD_READ, 2'd0);
        cmd_i       = CMD_READ;
        cmd_index_i = 2'd1;
        step();
        cmd_i = CMD_NONE;
        step();
        checks++;
        if (cmd_busy_o !== 1'b1 || ca_o !== 8'h01) begin
            failures++;
            $display("FAIL rst_pre_p1 busy=%b ca=%h exp 1/01", cmd_busy_o, ca_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (cs_n_o !== 1'b1 || ca_o !== 8'h00 || cmd_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort cs_n=%b ca=%h busy=%b exp 1/00/0", cs_n_o, ca_o, cmd_busy_o);
        end
        bad = 0;
        for (int t = 0; t < 24; t++) begin
            step();
            if (data_en_o !== 1'b0 || err_o !== 3'b000 || cs_n_o !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_discard bad_cycles=%0d exp 0", bad);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_i       = CMD_NONE;
        cmd_index_i = 2'd0;
        bank = '0;
        bg   = '0;
        row  = '0;
        col  = '0;
        bg[1]   = 2'd2;  bank[1] = 2'd1;  col[1] = 10'h155;
        bg[2]   = 2'd1;  bank[2] = 2'd3;  row[2] = 16'hA5C3;  col[2] = 10'h2AB;
        bg[0]   = 2'd0;  bank[0] = 2'd2;  col[0] = 10'h0F0;
        row[3]  = 16'h1234;  col[3] = 10'h3FF;

        test_reset();
        test_activate();
        test_read();
        test_back_to_back();
        test_spaced_reads();
        test_window_full();
        test_cmd_while_busy();
        test_reset_mid_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
